// File: rtl/btn_press_frontend.sv
// btn_press_frontend: button input conditioner for the whack-a-mole game.
// Synchronises the raw pads, debounces every channel on its own, turns
// debounced rising edges into one-cycle presses, and accumulates the presses
// into an event mask that the game FSM collects through a valid/ready handshake.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   btn_raw      in   asynchronous button pins, active-high
//   btn_level    out  debounced level per button
//   btn_press    out  one-cycle pulse on a debounced 0->1 transition
//   evt_valid    out  event mask holds at least one unconsumed press
//   evt_mask     out  OR of all presses not yet consumed
//   evt_ready    in   consumer takes the event this cycle
//   evt_overflow out  sticky: a press merged into an already-pending bit
module btn_press_frontend #(
    parameter int unsigned NUM_BTN         = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               evt_valid,
    output logic [NUM_BTN-1:0] evt_mask,
    input  logic               evt_ready,
    output logic               evt_overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic               valid_q;
    logic               valid_d;
    logic [NUM_BTN-1:0] mask_q;
    logic [NUM_BTN-1:0] mask_d;
    logic               ovf_q;
    logic               ovf_d;

    // Per-channel debounce: count consecutive edges where s2 disagrees with
    // the accepted level; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Press detect and event accumulation; presses landing in the consume
    // cycle start the next event instead of being dropped.
    always_comb begin
        press_d = level_d & ~level_q;
        mask_d  = mask_q | press_d;
        valid_d = valid_q | (|press_d);
        if (valid_q && evt_ready) begin
            mask_d  = press_d;
            valid_d = |press_d;
        end
        ovf_d = ovf_q | (valid_q & ~evt_ready & (|(press_d & mask_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            press_q <= '0;
            valid_q <= 1'b0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            press_q <= press_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level    = level_q;
    assign btn_press    = press_q;
    assign evt_valid    = valid_q;
    assign evt_mask     = mask_q;
    assign evt_overflow = ovf_q;

endmodule
